// File: rtl/sdpb_fifo_ctrl.sv
// FWFT FIFO controller for an external SDPB line RAM with 1-cycle registered read.
// A 2-entry output buffer hides the RAM latency to sustain one word per clock.
module sdpb_fifo_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int AFULL_TH = 2**ADDR_W - 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full,
    output logic              overflow,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_oce,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] AFULL_LV = (ADDR_W+2)'(AFULL_TH);

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              rd_pend;
    logic [1:0]        obuf_cnt;
    logic [DATA_W-1:0] obuf0;
    logic [DATA_W-1:0] obuf1;
    logic [1:0]        wr_slot;
    logic              push;
    logic              pop;
    logic              rd_issue;

    // A word becomes readable only the cycle after its write, so read and
    // write addresses can never collide in the same cycle.
    assign ram_cnt  = wr_ptr - rd_ptr;
    assign s_ready  = rst_n & (ram_cnt != FULL_CNT) & ~flush;
    assign push     = s_valid & s_ready;
    assign m_valid  = (obuf_cnt != 2'd0);
    assign pop      = m_valid & m_ready;
    assign rd_issue = ~flush & (ram_cnt != '0) &
                      (({1'b0, obuf_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));

    assign ram_cea     = push;
    assign ram_ada     = wr_ptr[ADDR_W-1:0];
    assign ram_din     = s_data;
    assign ram_ceb     = rd_issue;
    assign ram_adb     = rd_ptr[ADDR_W-1:0];
    assign ram_oce     = 1'b1;
    assign m_data      = obuf0;
    assign almost_full = (level >= AFULL_LV);

    assign wr_slot = obuf_cnt - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_pend  <= 1'b0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_pend  <= 1'b0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue)
                rd_ptr <= rd_ptr + 1'b1;
            rd_pend <= rd_issue;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (s_valid && !s_ready)
                overflow <= 1'b1;
        end
    end

    // Pop shifts the tail forward first; the returning RAM word then lands in
    // the first free slot, which is the head when the buffer drains to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else if (flush) begin
            obuf_cnt <= 2'd0;
        end else begin
            obuf_cnt <= obuf_cnt + {1'b0, rd_pend} - {1'b0, pop};
            if (pop)
                obuf0 <= obuf1;
            if (rd_pend) begin
                if (wr_slot == 2'd0)
                    obuf0 <= ram_dout;
                else
                    obuf1 <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdpb_fifo_ctrl.sv
// Directed bench for sdpb_fifo_ctrl with a behavioural 4096x8 RAM and an
// in-order scoreboard on the output stream.
module tb_sdpb_fifo_ctrl;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W+1:0] level;
    logic              almost_full;
    logic              overflow;
    logic              ram_cea;
    logic [ADDR_W-1:0] ram_ada;
    logic [DATA_W-1:0] ram_din;
    logic              ram_ceb;
    logic [ADDR_W-1:0] ram_adb;
    logic              ram_oce;
    logic [DATA_W-1:0] ram_dout;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    logic [DATA_W-1:0] sb_q [$];
    int exp_wa = 0;
    int exp_ra = 0;

    always #5 clk = ~clk;

    sdpb_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level), .almost_full(almost_full), .overflow(overflow),
        .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
        .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_oce(ram_oce),
        .ram_dout(ram_dout)
    );

    // Registered-output RAM: read data appears one clock after ram_ceb.
    always @(posedge clk) begin
        if (ram_cea)
            mem[ram_ada] <= ram_din;
        if (ram_ceb)
            ram_dout <= mem[ram_adb];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_cnt++;
        if (observed !== expected) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Scoreboard and address tracking, sampled mid-cycle on stable signals.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb_q.delete();
            exp_wa = 0;
            exp_ra = 0;
        end else begin
            if (ram_cea && ram_ceb)
                checkOutput("no_raw_collision", 32'(ram_adb != ram_ada), 1);
            if (ram_cea) begin
                checkOutput("ram_ada", 32'(ram_ada), 32'(exp_wa % 4096));
                checkOutput("ram_din", 32'(ram_din), 32'(s_data));
                exp_wa++;
            end
            if (ram_ceb) begin
                checkOutput("ram_adb", 32'(ram_adb), 32'(exp_ra % 4096));
                exp_ra++;
            end
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0)
                    checkOutput("sb_unexpected_pop", 1, 0);
                else
                    checkOutput("sb_data", 32'(m_data), 32'(sb_q.pop_front()));
            end
            if (s_valid && s_ready)
                sb_q.push_back(s_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sv, input logic [DATA_W-1:0] sd,
                                 input logic mr, input logic fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
    endtask

    task automatic drainAll(input string tag, input int limit, output int pops);
        int n;
        pops = 0;
        n = 0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        while (n < limit) begin
            @(negedge clk);
            if (!m_valid)
                break;
            pops++;
            step();
            n++;
        end
        checkOutput({tag, "_drain_in_time"}, 32'(n < limit), 1);
        checkOutput({tag, "_level_empty"}, 32'(level), 0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pops;
        int pushes;
        int burst_left;
        logic burst_on;

        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m_valid", 32'(m_valid), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_almost_full", 32'(almost_full), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_ram_cea", 32'(ram_cea), 0);
        checkOutput("rst_ram_ceb", 32'(ram_ceb), 0);
        checkOutput("ram_oce", 32'(ram_oce), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_s_ready_after", 32'(s_ready), 1);
        step();

        $display("[TB] test 1: push 0x01..0x10 with consumer stalled");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
            @(negedge clk);
            if (i == 0) begin
                checkOutput("t1_first_cea", 32'(ram_cea), 1);
                checkOutput("t1_first_ada", 32'(ram_ada), 0);
                checkOutput("t1_first_din", 32'(ram_din), 1);
                checkOutput("t1_first_no_ceb", 32'(ram_ceb), 0);
            end
            if (i == 1) begin
                checkOutput("t1_first_ceb", 32'(ram_ceb), 1);
                checkOutput("t1_first_adb", 32'(ram_adb), 0);
            end
            if (i == 2)
                checkOutput("t1_m_valid_t2", 32'(m_valid), 0);
            if (i == 3) begin
                checkOutput("t1_m_valid_t3", 32'(m_valid), 1);
                checkOutput("t1_m_data_t3", 32'(m_data), 1);
            end
            step();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_level", 32'(level), 16);
        checkOutput("t1_head", 32'(m_data), 32'h01);
        checkOutput("t1_m_valid", 32'(m_valid), 1);
        step();

        $display("[TB] test 2: 10000 words push+pop");
        pops = 0;
        pushes = 0;
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'b1, 8'(i * 13 + 5), 1'b1, 1'b0);
            @(negedge clk);
            if (m_valid)
                pops++;
            if (s_ready)
                pushes++;
            step();
        end
        checkOutput("t2_pop_rate", 32'(pops), 10000);
        checkOutput("t2_push_rate", 32'(pushes), 10000);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t2_level_steady", 32'(level), 16);
        step();
        drainAll("t2", 100, pops);
        checkOutput("t2_drain_count", 32'(pops), 16);

        $display("[TB] test 3: fill to full, then overflow");
        for (int i = 0; i < 4098; i++) begin
            applyStimulus(1'b1, 8'(i ^ 8'h5A), 1'b0, 1'b0);
            @(negedge clk);
            if (i == 4079) begin
                checkOutput("t3_level_4079", 32'(level), 4079);
                checkOutput("t3_afull_below", 32'(almost_full), 0);
            end
            if (i == 4080) begin
                checkOutput("t3_level_4080", 32'(level), 4080);
                checkOutput("t3_afull_at", 32'(almost_full), 1);
            end
            if (i == 4097)
                checkOutput("t3_last_ready", 32'(s_ready), 1);
            step();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_full_not_ready", 32'(s_ready), 0);
        checkOutput("t3_level_full", 32'(level), 4098);
        checkOutput("t3_no_overflow", 32'(overflow), 0);
        step();
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_extra_no_write", 32'(ram_cea), 0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_overflow_set", 32'(overflow), 1);
        checkOutput("t3_level_unchanged", 32'(level), 4098);
        step();
        drainAll("t3", 5000, pops);
        checkOutput("t3_drain_count", 32'(pops), 4098);
        checkOutput("t3_overflow_sticky", 32'(overflow), 1);

        $display("[TB] test 5: flush with a read in flight");
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5_flush_not_ready", 32'(s_ready), 0);
        checkOutput("t5_flush_no_cea", 32'(ram_cea), 0);
        checkOutput("t5_flush_no_ceb", 32'(ram_ceb), 0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_level_cleared", 32'(level), 0);
        checkOutput("t5_m_valid_cleared", 32'(m_valid), 0);
        checkOutput("t5_overflow_cleared", 32'(overflow), 0);
        checkOutput("t5_ready_again", 32'(s_ready), 1);
        repeat (3) step();
        @(negedge clk);
        checkOutput("t5_return_discarded", 32'(m_valid), 0);
        step();
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        checkOutput("t5_aa_valid", 32'(m_valid), 1);
        checkOutput("t5_aa_first", 32'(m_data), 32'hAA);
        checkOutput("t5_aa_level", 32'(level), 1);
        step();
        drainAll("t5", 20, pops);

        $display("[TB] test 4: bursty producer, random consumer");
        burst_left = 0;
        burst_on = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (burst_left == 0) begin
                burst_on = ~burst_on;
                burst_left = $urandom_range(1, 12);
            end
            burst_left--;
            applyStimulus(burst_on, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            step();
        end
        drainAll("t4", 5000, pops);
        checkOutput("t4_no_overflow", 32'(overflow), 0);

        $display("[TB] test 6: reset mid-stream");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_m_valid_drop", 32'(m_valid), 0);
        checkOutput("t6_cea_drop", 32'(ram_cea), 0);
        checkOutput("t6_ceb_drop", 32'(ram_ceb), 0);
        checkOutput("t6_level_zero", 32'(level), 0);
        repeat (2) @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_ready_after", 32'(s_ready), 1);
        checkOutput("t6_m_valid_after", 32'(m_valid), 0);
        step();
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        checkOutput("t6_post_reset_data", 32'(m_data), 32'h3C);
        checkOutput("t6_post_reset_valid", 32'(m_valid), 1);
        step();
        drainAll("t6", 20, pops);
        checkOutput("sb_leftover", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
